mul_unit: RTL
=============

Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier for the EX stage of the MIPS matrix-multiply pipeline.
- Consumes the two operands read from the register file (read_data1/read_data2) and produces a 64-bit product.
- Returns a write-back request addressed to one of the saved registers s0-s7 (indices 16-23).
- One multiply in flight; start/busy/done handshake toward pipeline control.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- REG_ADDR_W, 5, register index width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled on rising edge.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with operands.
- op_a  in  WIDTH  multiplicand (register file read_data1).
- op_b  in  WIDTH  multiplier (register file read_data2).
- dest_reg  in  REG_ADDR_W  destination register index; latched with operands.
- flush  in  1  synchronous abort of the in-flight multiply.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when the product is valid.
- result_lo  out  WIDTH  product bits [WIDTH-1:0].
- result_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH].
- wb_reg  out  REG_ADDR_W  latched dest_reg.
- wb_en  out  1  write-back strobe to the register file reg_write.

Behaviour:
- Clock and reset: one clock, clock; reset_n is asynchronous and active-low.
- Reset values: state IDLE; busy, done, wb_en = 0; result_lo, result_hi, wb_reg, counter, accumulator = 0.
- Reset takes effect immediately, including mid-operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 + flush=0 at edge E0:
  - Latch operands, signed_mode and dest_reg.
  - Signed mode: store magnitudes and sign = a_msb XOR b_msb.
  - Clear accumulator; counter=0; go to RUN.
- RUN, each edge:
  - If multiplier LSB is set, add the multiplicand into the upper half of the accumulator, keeping the carry.
  - Shift right one bit; counter+1.
  - The edge with counter=WIDTH-1 transitions to DONE.
- Entry to DONE:
  - Product = accumulator, negated (two's complement over 2*WIDTH) if the latched sign is 1.
  - Write the product to result_hi/result_lo.
- Timing:
  - busy=1 in cycles E0+1 .. E0+WIDTH.
  - done=1 for exactly cycle E0+WIDTH+1.
- wb_en = done AND (16 <= wb_reg <= 23); otherwise done is still asserted but wb_en stays 0.
- result_hi, result_lo and wb_reg hold until the next product is written; they are not cleared on accept.
- start while in RUN is ignored (no queueing).
- start during the DONE cycle is accepted: back-to-back throughput of one result per WIDTH+1 cycles.
- flush=1:
  - In any state, next state is IDLE.
  - No done, no wb_en.
  - Results keep their previous values.
  - flush has priority over start on the same edge.
- DONE with start=0 returns to IDLE on the next edge.
- Magnitude of the most negative value (0x80000000) is represented unsigned in WIDTH bits; no overflow.

Test Plan:
- Reset, then unsigned 3 x 5, dest 16, start at edge 0 -> busy cycles 1-32, done and wb_en in cycle 33, hi=0x00000000, lo=0x0000000F, wb_reg=16.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed 0xFFFFFFF9 (-7) x 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Signed -1 x -1 -> hi=0, lo=1.
- Handshake sequence:
  - start pulse at cycle 10 while busy -> ignored; only one done.
  - start in the done cycle -> second done exactly 33 cycles later.
  - flush at cycle 15 of a run -> no done, results unchanged, busy low next cycle.
- Abort and write-back gating:
  - reset_n low mid-run -> all outputs 0 immediately, state IDLE.
  - dest_reg=8 multiply -> done=1, wb_en=0, wb_reg=8.
  - dest_reg=23 -> wb_en=1.

Source files
------------

// File: rtl/mul_unit.sv
`default_nettype none
// mul_unit: iterative radix-2 shift-add multiplier (one multiply in flight) with
// start/busy/done handshake and write-back request gated to registers s0-s7.
// Revision: 1.0
module mul_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result_lo,
  output logic [WIDTH-1:0]      result_hi,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  wb_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]      c_last   = CNT_W'(WIDTH - 1);
  localparam logic [REG_ADDR_W-1:0] c_wb_min = REG_ADDR_W'(16);
  localparam logic [REG_ADDR_W-1:0] c_wb_max = REG_ADDR_W'(23);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [WIDTH-1:0]        r_mcand;
  logic [2*WIDTH-1:0]      r_acc;
  logic                    r_sign;
  logic [REG_ADDR_W-1:0]   r_dest;
  logic [WIDTH-1:0]        r_res_lo;
  logic [WIDTH-1:0]        r_res_hi;
  logic [REG_ADDR_W-1:0]   r_wb_reg;

  logic                    w_accept;
  logic                    w_last;
  logic [WIDTH-1:0]        w_a_mag;
  logic [WIDTH-1:0]        w_b_mag;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_upper;
  logic [2*WIDTH-1:0]      w_acc_next;
  logic [2*WIDTH-1:0]      w_prod;

  assign w_accept = (r_state != S_RUN) && start && !flush;
  assign w_last   = (r_state == S_RUN) && (r_cnt == c_last);

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign w_a_mag = (signed_mode && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_b_mag = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;

  // Low half of the accumulator starts as the multiplier and is consumed LSB first.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_upper    = r_acc[0] ? w_sum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_acc_next = {w_upper, r_acc[WIDTH-1:1]};
  assign w_prod     = r_sign ? -w_acc_next : w_acc_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = start ? S_RUN : S_IDLE;
        S_RUN:   w_next = (r_cnt == c_last) ? S_DONE : S_RUN;
        S_DONE:  w_next = start ? S_RUN : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_sign   <= 1'b0;
      r_dest   <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_wb_reg <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_mcand <= w_a_mag;
      r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
      r_sign  <= signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      r_dest  <= dest_reg;
    end else if ((r_state == S_RUN) && !flush) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_res_lo <= w_prod[WIDTH-1:0];
        r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_wb_reg <= r_dest;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign wb_reg    = r_wb_reg;
  assign wb_en     = done && (r_wb_reg >= c_wb_min) && (r_wb_reg <= c_wb_max);

endmodule
`default_nettype wire
